// File: rtl/bincnt_seq.sv
// Sequential popcount: a WIDTH-bit word is streamed one nibble per cycle through a shared 4-bit sorter.
// Optional thermometer-code checker on the sorter output is enabled by defining BINCNT_THERM_CHECK_EN.

module sorter4b (
    input  logic [3:0] a,
    output logic [3:0] y
);
    logic [3:0] s1;
    logic [3:0] s2;

    // Compare-swap network; ones migrate toward bit 0
    always_comb begin
        s1[0] = a[0] | a[1];
        s1[1] = a[0] & a[1];
        s1[2] = a[2] | a[3];
        s1[3] = a[2] & a[3];
        s2[0] = s1[0] | s1[2];
        s2[2] = s1[0] & s1[2];
        s2[1] = s1[1] | s1[3];
        s2[3] = s1[1] & s1[3];
        y[0]  = s2[0];
        y[1]  = s2[1] | s2[2];
        y[2]  = s2[1] & s2[2];
        y[3]  = s2[3];
    end
endmodule

module bincnt_seq #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned CW    = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] x,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [CW-1:0]    y,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             err
);
    localparam int unsigned S  = WIDTH / 4;
    localparam int unsigned IW = (S > 1) ? $clog2(S) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state, state_nx;
    logic [WIDTH-1:0] sh, sh_nx;
    logic [CW-1:0]    acc, acc_nx;
    logic [IW-1:0]    idx, idx_nx;
    logic [3:0]       srt_y;
    logic [2:0]       cnt;

    sorter4b u_sorter (
        .a (sh[3:0]),
        .y (srt_y)
    );

    // Thermometer to binary by priority
    always_comb begin
        cnt = 3'd0;
        if (srt_y[3])      cnt = 3'd4;
        else if (srt_y[2]) cnt = 3'd3;
        else if (srt_y[1]) cnt = 3'd2;
        else if (srt_y[0]) cnt = 3'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            sh    <= '0;
            acc   <= '0;
            idx   <= '0;
        end else begin
            state <= state_nx;
            sh    <= sh_nx;
            acc   <= acc_nx;
            idx   <= idx_nx;
        end
    end

    always_comb begin
        state_nx = state;
        sh_nx    = sh;
        acc_nx   = acc;
        idx_nx   = idx;
        case (state)
            IDLE: begin
                if (in_valid) begin
                    sh_nx    = x;
                    acc_nx   = '0;
                    idx_nx   = '0;
                    state_nx = RUN;
                end
            end
            RUN: begin
                acc_nx = acc + CW'(cnt);
                sh_nx  = sh >> 4;
                idx_nx = IW'(idx + 1'b1);
                if (idx == IW'(S - 1)) state_nx = DONE;
            end
            DONE: begin
                if (out_ready) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign y         = acc;

`ifdef BINCNT_THERM_CHECK_EN
    logic therm_ok;
    logic err_q;

    assign therm_ok = (srt_y == 4'b0000) || (srt_y == 4'b0001) || (srt_y == 4'b0011) ||
                      (srt_y == 4'b0111) || (srt_y == 4'b1111);

    // Sticky until reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                          err_q <= 1'b0;
        else if (state == RUN && !therm_ok)  err_q <= 1'b1;
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif
endmodule

// File: tb/tb_bincnt_seq.sv
// Scoreboard bench for bincnt_seq (WIDTH=16): driver pushes expected popcounts, monitor pops on output handshake.
// The error-injection scenario is compiled in when BINCNT_THERM_CHECK_EN is defined.

module tb_bincnt_seq;
    localparam int unsigned WIDTH = 16;
    localparam int unsigned CW    = 5;
    localparam int unsigned S     = WIDTH / 4;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [WIDTH-1:0] x;
    logic             in_valid;
    logic             in_ready;
    logic [CW-1:0]    y;
    logic             out_valid;
    logic             out_ready;
    logic             err;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int acc_cyc = 0;
    int exp_q[$];
    logic exp_err = 1'b0;
    logic rnd_or  = 1'b0;
    logic prev_ov = 1'b0;
    logic [CW-1:0] held_y = '0;

    bincnt_seq #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .x         (x),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .y         (y),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .err       (err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Random consumer backpressure when enabled
    always @(posedge clk) begin
        #1;
        if (rnd_or) out_ready = 1'($urandom);
    end

    // Monitor: sampled on the falling edge, so a handshake seen here completes on the next rising edge
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_ov = 1'b0;
        end else begin
            if (out_valid && !prev_ov) begin
                chk("latency", cyc - acc_cyc, S);
                held_y = y;
            end else if (out_valid) begin
                chk("y_stable", int'(y), int'(held_y));
            end
            if (out_valid) chk("in_ready_low_in_done", int'(in_ready), 0);
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_output", 1, 0);
                end else begin
                    chk("y", int'(y), exp_q.pop_front());
                    chk("err", int'(err), int'(exp_err));
                end
            end
            prev_ov = out_valid;
        end
    end

    task automatic send(input logic [WIDTH-1:0] w, input int e);
        int n = 0;
        x = w;
        in_valid = 1'b1;
        while (!in_ready && n < 200) begin
            tick();
            n++;
        end
        if (n >= 200) chk("accept_timeout", 1, 0);
        tick();
        acc_cyc = cyc;
        exp_q.push_back(e);
        in_valid = 1'b0;
        x = WIDTH'($urandom);
    endtask

    task automatic drain();
        int n = 0;
        while ((exp_q.size() > 0 || out_valid) && n < 500) begin
            tick();
            n++;
        end
        if (n >= 500) chk("drain_timeout", 1, 0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        exp_q.delete();
        exp_err = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    initial begin
        logic [WIDTH-1:0] w;
        int n;
        rst_n = 1'b0;
        x = '0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        #1;
        chk("rst_in_ready", int'(in_ready), 1);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_y", int'(y), 0);
        chk("rst_err", int'(err), 0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        // Zero word: in_ready drops immediately after acceptance
        send(16'h0000, 0);
        chk("in_ready_drop", int'(in_ready), 0);
        drain();
        send(16'hFFFF, 16);
        drain();
        send(16'hA5F0, 8);
        drain();
        for (int p = 0; p < 16; p++) begin
            w = WIDTH'(p) << 12;
            send(w, $countones(w));
        end
        drain();

        // Backpressure with input noise
        out_ready = 1'b0;
        send(16'h1234, 5);
        n = 0;
        while (!out_valid && n < 50) begin
            tick();
            n++;
        end
        chk("bp_out_valid", int'(out_valid), 1);
        for (int i = 0; i < 6; i++) begin
            x = WIDTH'($urandom);
            in_valid = 1'($urandom);
            tick();
            chk("bp_hold_valid", int'(out_valid), 1);
            chk("bp_in_ready", int'(in_ready), 0);
            chk("bp_y", int'(y), 5);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        drain();
        send(16'h8001, 2);
        drain();

        // Randomized words with random consumer stalls
        rnd_or = 1'b1;
        for (int i = 0; i < 40; i++) begin
            w = WIDTH'($urandom);
            send(w, $countones(w));
            n = $urandom_range(0, 3);
            for (int k = 0; k < n; k++) tick();
        end
        drain();
        rnd_or = 1'b0;
        tick();
        out_ready = 1'b1;

        // Reset during RUN at idx==2
        send(16'hFFFF, 16);
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", int'(out_valid), 0);
        chk("midrst_y", int'(y), 0);
        chk("midrst_in_ready", int'(in_ready), 1);
        exp_q.delete();
        tick();
        rst_n = 1'b1;
        tick();
        send(16'h0101, 2);
        drain();

`ifdef BINCNT_THERM_CHECK_EN
        // Illegal sorter code on the first RUN cycle: slice 0 counts as 3 by priority
        x = 16'h0000;
        in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 50) begin
            tick();
            n++;
        end
        tick();
        acc_cyc = cyc;
        in_valid = 1'b0;
        force dut.srt_y = 4'b0101;
        exp_q.push_back(3);
        tick();
        release dut.srt_y;
        exp_err = 1'b1;
        chk("err_set", int'(err), 1);
        drain();
        send(16'h00F0, 4);
        drain();
        chk("err_sticky", int'(err), 1);
        do_reset();
        chk("err_cleared", int'(err), 0);
`else
        chk("err_tied_low", int'(err), 0);
`endif
        send(16'h7777, 12);
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1, "watchdog");
    end
endmodule
